rr_arb_4_1: RTL and testbench



---
 rtl/rr_arb_4_1.sv | 79 +++++++
 tb/tb_rr_arb_4_1.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/rr_arb_4_1.sv
// Four-source round-robin arbiter feeding one registered output word plus its source index.
// One cycle from grant to out_*; in_ready is gated by load = !out_valid || out_ready, so a stalled output blocks every source.
module rr_arb_4_1 #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] d0,
   input  logic [WIDTH-1:0] d1,
   input  logic [WIDTH-1:0] d2,
   input  logic [WIDTH-1:0] d3,
   input  logic [3:0]       in_valid,
   output logic [3:0]       in_ready,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [1:0]       out_sel
);

   logic [1:0]       r_last;
   logic             r_out_valid;
   logic [WIDTH-1:0] r_out_data;
   logic [1:0]       r_out_sel;

   logic             w_load;
   logic             w_any;
   logic [1:0]       w_idx;
   logic [1:0]       w_winner;
   logic [WIDTH-1:0] w_win_data;

   assign w_load = !r_out_valid || out_ready;
   assign w_any  = |in_valid;

   // Scan from lowest priority to highest so the last hit is the winner.
   always_comb begin
      w_winner = r_last;
      w_idx    = r_last;
      for (int k = 4; k >= 1; k--) begin
         w_idx = r_last + 2'(k);
         if (in_valid[w_idx]) begin
            w_winner = w_idx;
         end
      end
   end

   always_comb begin
      case (w_winner)
         2'd0: w_win_data = d0;
         2'd1: w_win_data = d1;
         2'd2: w_win_data = d2;
         2'd3: w_win_data = d3;
      endcase
   end

   assign in_ready = (w_load && w_any && !rst) ? (4'b0001 << w_winner) : 4'b0000;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_last      <= 2'd3;
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_out_sel   <= 2'd0;
      end else if (w_load) begin
         if (w_any) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_win_data;
            r_out_sel   <= w_winner;
            r_last      <= w_winner;
         end else begin
            r_out_valid <= 1'b0;
         end
      end
   end

   assign out_valid = r_out_valid;
   assign out_data  = r_out_data;
   assign out_sel   = r_out_sel;

endmodule

// File: tb/tb_rr_arb_4_1.sv
// Self-checking bench for rr_arb_4_1 against a behavioural round-robin model.
module tb_rr_arb_4_1;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] d_arr [4];
   logic [3:0] in_valid;
   logic [3:0] in_ready;
   logic       out_valid;
   logic       out_ready;
   logic [3:0] out_data;
   logic [1:0] out_sel;

   int checks = 0;
   int errors = 0;

   // behavioural model state
   int         m_last;
   logic       m_valid;
   logic [3:0] m_data;
   logic [1:0] m_sel;

   always #5 clk = ~clk;

   rr_arb_4_1 #(.WIDTH(4)) dut (
      .clk(clk), .rst(rst),
      .d0(d_arr[0]), .d1(d_arr[1]), .d2(d_arr[2]), .d3(d_arr[3]),
      .in_valid(in_valid), .in_ready(in_ready),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_sel(out_sel)
   );

   function automatic logic [3:0] exp_ready();
      int s;
      if (rst) return 4'b0000;
      if (m_valid && !out_ready) return 4'b0000;
      for (int k = 1; k <= 4; k++) begin
         s = (m_last + k) % 4;
         if (in_valid[s]) return 4'(1 << s);
      end
      return 4'b0000;
   endfunction

   function automatic int onehot_idx(input logic [3:0] g);
      for (int i = 0; i < 4; i++) if (g[i]) return i;
      return -1;
   endfunction

   task automatic model_reset();
      m_last = 3; m_valid = 1'b0; m_data = 4'd0; m_sel = 2'd0;
   endtask

   // Advance one clock edge, updating the model with the grant decided before the edge.
   task automatic tick();
      logic [3:0] g;
      int s;
      g = exp_ready();
      s = onehot_idx(g);
      @(posedge clk);
      if (s >= 0) begin
         m_valid = 1'b1; m_data = d_arr[s]; m_sel = 2'(s); m_last = s;
      end else if (!m_valid || out_ready) begin
         m_valid = 1'b0;
      end
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b1; in_valid = 4'b0000; out_ready = 1'b0;
      model_reset();
      @(negedge clk); @(negedge clk);
      rst = 1'b0;
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 4'b1111; out_ready = 1'b1;
      for (int i = 0; i < 4; i++) d_arr[i] = 4'(i + 1);
      model_reset();
      @(negedge clk); #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
      checks++; if (out_data !== 4'd0) begin errors++; $display("FAIL reset_out_data got %h want 0", out_data); end
      checks++; if (out_sel !== 2'd0) begin errors++; $display("FAIL reset_out_sel got %0d want 0", out_sel); end
      checks++; if (in_ready !== 4'b0000) begin errors++; $display("FAIL reset_in_ready got %b want 0000", in_ready); end
      in_valid = 4'b0000;
      @(negedge clk);
      rst = 1'b0;
      #1;
      checks++; if (in_ready !== 4'b0000) begin errors++; $display("FAIL idle_in_ready got %b want 0000", in_ready); end
   endtask

   task automatic test_rotation();
      logic [3:0] er [5];
      logic [3:0] vals [4];
      er = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      vals = '{4'hA, 4'hB, 4'hC, 4'hD};
      do_reset();
      for (int i = 0; i < 4; i++) d_arr[i] = vals[i];
      in_valid = 4'b1111; out_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         #1;
         checks++; if (in_ready !== er[i]) begin errors++; $display("FAIL rot_in_ready[%0d] got %b want %b", i, in_ready, er[i]); end
         tick();
         checks++; if (out_valid !== 1'b1 || out_sel !== 2'(i % 4) || out_data !== vals[i % 4]) begin
            errors++; $display("FAIL rot_out[%0d] got v=%b sel=%0d d=%h want v=1 sel=%0d d=%h", i, out_valid, out_sel, out_data, i % 4, vals[i % 4]);
         end
      end
   endtask

   task automatic test_backpressure();
      do_reset();
      d_arr[2] = 4'd5; in_valid = 4'b0100; out_ready = 1'b1;
      tick();
      in_valid = 4'b1011; out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         checks++; if (in_ready !== 4'b0000) begin errors++; $display("FAIL bp_in_ready[%0d] got %b want 0000", i, in_ready); end
         checks++; if (out_valid !== 1'b1 || out_sel !== 2'd2 || out_data !== 4'd5) begin
            errors++; $display("FAIL bp_hold[%0d] got v=%b sel=%0d d=%h want v=1 sel=2 d=5", i, out_valid, out_sel, out_data);
         end
         tick();
      end
      out_ready = 1'b1;
      #1;
      checks++; if (in_ready !== 4'b1000) begin errors++; $display("FAIL bp_next_grant got %b want 1000", in_ready); end
      tick();
      checks++; if (out_sel !== 2'd3) begin errors++; $display("FAIL bp_next_sel got %0d want 3", out_sel); end
   endtask

   task automatic test_sparse();
      do_reset();
      in_valid = 4'b0010; out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         checks++; if (in_ready !== 4'b0010) begin errors++; $display("FAIL sparse_grant[%0d] got %b want 0010", i, in_ready); end
         tick();
      end
      in_valid = 4'b0011;
      #1;
      checks++; if (in_ready !== 4'b0001) begin errors++; $display("FAIL sparse_src0 got %b want 0001", in_ready); end
      tick();
      #1;
      checks++; if (in_ready !== 4'b0010) begin errors++; $display("FAIL sparse_src1 got %b want 0010", in_ready); end
      tick();
   endtask

   task automatic test_x_isolation();
      do_reset();
      d_arr[3] = 4'bxxxx; d_arr[0] = 4'd7; in_valid = 4'b0001; out_ready = 1'b1;
      tick();
      checks++; if (out_data !== 4'd7 || out_sel !== 2'd0 || $isunknown(out_data)) begin
         errors++; $display("FAIL x_iso got sel=%0d d=%b want sel=0 d=0111", out_sel, out_data);
      end
      d_arr[3] = 4'd0;
   endtask

   task automatic test_drain();
      in_valid = 4'b0000; out_ready = 1'b1;
      #1;
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL drain_held got %b want 1", out_valid); end
      checks++; if (in_ready !== 4'b0000) begin errors++; $display("FAIL drain_in_ready got %b want 0000", in_ready); end
      tick();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL drain_empty got %b want 0", out_valid); end
      checks++; if (in_ready !== 4'b0000) begin errors++; $display("FAIL drain_in_ready2 got %b want 0000", in_ready); end
   endtask

   task automatic test_async_reset();
      do_reset();
      in_valid = 4'b0100; out_ready = 1'b1; d_arr[2] = 4'd9;
      tick();
      in_valid = 4'b1111; out_ready = 1'b0;
      #1;
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL arst_pre got %b want 1", out_valid); end
      #2 rst = 1'b1;
      #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL arst_out_valid got %b want 0", out_valid); end
      checks++; if (in_ready !== 4'b0000) begin errors++; $display("FAIL arst_in_ready got %b want 0000", in_ready); end
      model_reset();
      @(negedge clk);
      rst = 1'b0; out_ready = 1'b1;
      #1;
      checks++; if (in_ready !== 4'b0001) begin errors++; $display("FAIL arst_first_grant got %b want 0001", in_ready); end
      tick();
      checks++; if (out_sel !== 2'd0 || out_data !== d_arr[0]) begin errors++; $display("FAIL arst_first_out got sel=%0d d=%h want sel=0 d=%h", out_sel, out_data, d_arr[0]); end
   endtask

   task automatic test_random();
      int wait_g [4];
      logic [3:0] g;
      int s;
      do_reset();
      for (int i = 0; i < 4; i++) wait_g[i] = 0;
      for (int cyc = 0; cyc < 400; cyc++) begin
         for (int i = 0; i < 4; i++) begin
            if (!in_valid[i] && $urandom_range(0, 1) == 1) begin
               in_valid[i] = 1'b1; d_arr[i] = 4'($urandom);
            end
         end
         out_ready = ($urandom_range(0, 3) != 0);
         #1;
         g = exp_ready();
         checks++; if (in_ready !== g) begin errors++; $display("FAIL rnd_in_ready[%0d] got %b want %b", cyc, in_ready, g); end
         checks++; if (out_valid !== m_valid || (m_valid && (out_data !== m_data || out_sel !== m_sel))) begin
            errors++; $display("FAIL rnd_out[%0d] got v=%b sel=%0d d=%h want v=%b sel=%0d d=%h", cyc, out_valid, out_sel, out_data, m_valid, m_sel, m_data);
         end
         s = onehot_idx(g);
         if (s >= 0) begin
            for (int i = 0; i < 4; i++) begin
               if (i != s && in_valid[i]) wait_g[i]++;
            end
            checks++; if (wait_g[s] > 3) begin errors++; $display("FAIL rnd_fair src=%0d waited %0d grants want <=3", s, wait_g[s]); end
            wait_g[s] = 0;
         end
         tick();
         if (s >= 0) in_valid[s] = 1'b0;
      end
   endtask

   initial begin
      rst = 1'b1; in_valid = 4'b0000; out_ready = 1'b0;
      for (int i = 0; i < 4; i++) d_arr[i] = 4'd0;
      model_reset();
      @(negedge clk);
      test_reset();
      test_rotation();
      test_backpressure();
      test_sparse();
      test_x_isolation();
      test_drain();
      test_async_reset();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
